phase_timer: RTL and testbench
==============================

PHASE_TIMER -- requirements
Module: phase_timer

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 2, giving the number of independent countdown channels (1..8).
REQ-002 The block SHALL have parameter WIDTH, default 4, giving the count width per channel in bits (2..16).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port Reset_Sync, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The block SHALL have port oneHz_Enable, input, 1 bit: a one-cycle tick strobe shared by all channels.
REQ-006 The block SHALL have port start, input, NUM_CH bits: per-channel load-and-run pulse.
REQ-007 The block SHALL have port stop, input, NUM_CH bits: per-channel abort pulse.
REQ-008 The block SHALL have port value, input, NUM_CH*WIDTH bits: per-channel load value; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-009 The block SHALL have port auto_reload, input, NUM_CH bits: per-channel mode, sampled at start (1 = periodic, 0 = one-shot).
REQ-010 The block SHALL have port pause, input, NUM_CH bits: per-channel level hold; this port exists only when PHASE_TIMER_PAUSE_EN is defined.
REQ-011 The block SHALL have port time_left, output, NUM_CH*WIDTH bits: per-channel remaining count, packed the same way as value.
REQ-012 The block SHALL have port busy, output, NUM_CH bits: high while the channel is not IDLE.
REQ-013 The block SHALL have port expired, output, NUM_CH bits: a one-cycle pulse per expiry event.

Function
REQ-014 Each channel SHALL implement the states IDLE and RUN, plus PAUSED when PHASE_TIMER_PAUSE_EN is defined.
REQ-015 Per-channel event priority SHALL be, from highest: start, stop, pause, tick.
REQ-016 A start in any state SHALL, on that edge, load time_left with value, capture value into a reload register, capture auto_reload, and enter RUN.
REQ-017 In RUN, a tick with time_left greater than 1 SHALL decrement time_left by 1.
REQ-018 In RUN, a tick with time_left equal to 1 SHALL set time_left to 0 and assert expired for exactly the next cycle.
REQ-019 On expiry in one-shot mode the channel SHALL enter IDLE and hold time_left at 0.
REQ-020 On expiry in periodic mode the channel SHALL reload time_left from the reload register on the same edge and remain in RUN.
REQ-021 A start with value 0 SHALL enter RUN with time_left 0, and the channel SHALL then expire on the first cycle after the start edge without waiting for a tick, applying the mode rules of REQ-019 and REQ-020.
REQ-022 A periodic channel whose reload value is 0 SHALL expire every cycle until stopped or restarted.
REQ-023 A start coincident with an expiring tick SHALL win: the channel reloads from the new value and expired SHALL NOT pulse.
REQ-024 A stop SHALL send the channel to IDLE with time_left 0 and no expired pulse, and SHALL have no effect when the channel is already in IDLE.
REQ-025 A tick in IDLE SHALL have no effect.
REQ-026 Channels SHALL be fully independent, with no shared state other than oneHz_Enable.
REQ-027 All outputs SHALL be registered, and busy SHALL equal (state != IDLE).

Reset
REQ-028 Asserting Reset_Sync SHALL immediately force every channel to IDLE, time_left to 0, the reload register to 0, the mode to one-shot, busy to 0 and expired to 0.
REQ-029 A reset mid-count SHALL discard the count with no expired pulse.
REQ-030 The first start SHALL be honoured on the first clock edge after Reset_Sync deasserts.

Configuration
REQ-031 With PHASE_TIMER_PAUSE_EN defined, the pause port SHALL exist, and a pause level in RUN SHALL enter PAUSED, freezing time_left and ignoring ticks.
REQ-032 With PHASE_TIMER_PAUSE_EN defined, deasserting pause SHALL return the channel to RUN, and start and stop SHALL still act while in PAUSED.
REQ-033 Without PHASE_TIMER_PAUSE_EN, the pause port and the PAUSED state SHALL be absent, with behaviour otherwise identical.

Structure
REQ-034 The package phase_timer_pkg SHALL hold the channel state enum (IDLE, RUN, PAUSED) and the default NUM_CH and WIDTH constants.
REQ-035 The sub-module phase_timer_ch SHALL implement one channel and be instantiated NUM_CH times in a generate loop, while the top level only slices and packs the buses.

Verification
REQ-036 With NUM_CH=2 and WIDTH=4: start[0] with value 3 and one-shot mode, then 3 ticks -> time_left[0] reads 3,2,1,0, expired[0] pulses once, busy[0] falls, and channel 1 is unaffected.
REQ-037 Periodic channel with value 2 and 6 ticks -> exactly 3 expired pulses, each one cycle wide, with time_left reloading to 2 after each.
REQ-038 Start with value 0 -> expired pulses on the cycle after the start edge with no tick applied.
REQ-039 Start with value 5 issued on the same edge as an expiring tick -> no expired pulse, and time_left reads 5.
REQ-040 Stop at time_left 2, then Reset_Sync asserted mid-count on the other channel -> both channels IDLE at 0 with no expired pulses, and Reset_Sync clears the outputs without waiting for a clock edge.
REQ-041 With PHASE_TIMER_PAUSE_EN defined: pause held across 4 ticks at time_left 3 -> time_left stays 3, then resumes to 2 on the first tick after pause is released.

Source files
------------

// File: rtl/phase_timer_pkg.sv
// phase_timer_pkg: shared channel state encoding and default sizing for phase_timer.
//   IDLE/RUN/PAUSED channel states; PAUSED is reachable only when PHASE_TIMER_PAUSE_EN is defined.
package phase_timer_pkg;
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2
   } ch_state_e;
   localparam int NUM_CH_DEF = 2;
   localparam int WIDTH_DEF  = 4;
endpackage

// File: rtl/phase_timer_ch.sv
// phase_timer_ch: one countdown channel of phase_timer.
//   clk, rst        : clock, asynchronous active-high reset
//   tick_i          : shared one-cycle tick strobe
//   start_i/stop_i  : load-and-run / abort pulses (start has priority)
//   value_i         : load value; auto_reload_i: periodic mode, sampled at start
//   pause_i         : level hold, present only with PHASE_TIMER_PAUSE_EN defined
//   time_left_o, busy_o, expired_o : registered remaining count, not-IDLE flag, expiry pulse
module phase_timer_ch
   import phase_timer_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tick_i,
   input  logic             start_i,
   input  logic             stop_i,
   input  logic [WIDTH-1:0] value_i,
   input  logic             auto_reload_i,
`ifdef PHASE_TIMER_PAUSE_EN
   input  logic             pause_i,
`endif
   output logic [WIDTH-1:0] time_left_o,
   output logic             busy_o,
   output logic             expired_o
);
   ch_state_e        state_q, state_d;
   logic [WIDTH-1:0] cnt_q, cnt_d, reload_q, reload_d;
   logic             mode_q, mode_d, exp_q, exp_d;
   logic             expire;
   // A zero count in RUN expires without waiting for a tick, which also makes a
   // periodic channel with reload 0 expire every cycle.
   assign expire = (state_q == RUN) && ((cnt_q == '0) || (tick_i && cnt_q == WIDTH'(1)));
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      reload_d = reload_q;
      mode_d   = mode_q;
      exp_d    = 1'b0;
      if (start_i) begin
         state_d  = RUN;
         cnt_d    = value_i;
         reload_d = value_i;
         mode_d   = auto_reload_i;
      end else if (stop_i) begin
         state_d = IDLE;
         cnt_d   = '0;
      end
`ifdef PHASE_TIMER_PAUSE_EN
      else if (state_q == RUN && pause_i) state_d = PAUSED;
      else if (state_q == PAUSED) state_d = pause_i ? PAUSED : RUN;
`endif
      else if (expire) begin
         exp_d   = 1'b1;
         state_d = mode_q ? RUN : IDLE;
         cnt_d   = mode_q ? reload_q : '0;
      end else if (state_q == RUN && tick_i) cnt_d = cnt_q - WIDTH'(1);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         reload_q <= '0;
         mode_q   <= 1'b0;
         exp_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         reload_q <= reload_d;
         mode_q   <= mode_d;
         exp_q    <= exp_d;
      end
   end
   assign time_left_o = cnt_q;
   assign busy_o      = (state_q != IDLE);
   assign expired_o   = exp_q;
endmodule

// File: rtl/phase_timer.sv
// phase_timer: NUM_CH independent countdown timers sharing one tick strobe.
//   clk, Reset_Sync (asynchronous active-high), oneHz_Enable (shared tick)
//   start/stop/auto_reload [NUM_CH], value [NUM_CH*WIDTH] (channel k at [k*WIDTH +: WIDTH])
//   pause [NUM_CH] : present only when PHASE_TIMER_PAUSE_EN is defined
//   time_left [NUM_CH*WIDTH], busy [NUM_CH], expired [NUM_CH] : registered outputs
module phase_timer
   import phase_timer_pkg::*;
#(
   parameter int NUM_CH = NUM_CH_DEF,
   parameter int WIDTH  = WIDTH_DEF
) (
   input  logic                    clk,
   input  logic                    Reset_Sync,
   input  logic                    oneHz_Enable,
   input  logic [NUM_CH-1:0]       start,
   input  logic [NUM_CH-1:0]       stop,
   input  logic [NUM_CH*WIDTH-1:0] value,
   input  logic [NUM_CH-1:0]       auto_reload,
`ifdef PHASE_TIMER_PAUSE_EN
   input  logic [NUM_CH-1:0]       pause,
`endif
   output logic [NUM_CH*WIDTH-1:0] time_left,
   output logic [NUM_CH-1:0]       busy,
   output logic [NUM_CH-1:0]       expired
);
   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      phase_timer_ch #(.WIDTH(WIDTH)) u_ch (
         .clk          (clk),
         .rst          (Reset_Sync),
         .tick_i       (oneHz_Enable),
         .start_i      (start[i]),
         .stop_i       (stop[i]),
         .value_i      (value[i*WIDTH +: WIDTH]),
         .auto_reload_i(auto_reload[i]),
`ifdef PHASE_TIMER_PAUSE_EN
         .pause_i      (pause[i]),
`endif
         .time_left_o  (time_left[i*WIDTH +: WIDTH]),
         .busy_o       (busy[i]),
         .expired_o    (expired[i])
      );
   end
endmodule

// File: tb/tb_phase_timer.sv
// tb_phase_timer: self-checking bench for phase_timer (NUM_CH=2, WIDTH=4).
module tb_phase_timer;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick = 1'b0;
   logic [1:0] start = '0, stop = '0, ar = '0, pause = '0;
   logic [7:0] value = '0;
   logic [7:0] tl;
   logic [1:0] busy, expired;
   int checks = 0, failures = 0;

   logic [3:0] m_cnt [2];
   logic [3:0] m_rel [2];
   logic       m_run [2], m_per [2], m_exp [2], m_pau [2];

   typedef struct {
      logic [1:0] st, sp, ar;
      logic [7:0] val;
      logic       tk;
      logic [7:0] tl;
      logic [1:0] bs, ex;
   } vec_t;
   vec_t tbl [$];

   phase_timer #(.NUM_CH(2), .WIDTH(4)) dut (
      .clk         (clk),
      .Reset_Sync  (rst),
      .oneHz_Enable(tick),
      .start       (start),
      .stop        (stop),
      .value       (value),
      .auto_reload (ar),
`ifdef PHASE_TIMER_PAUSE_EN
      .pause       (pause),
`endif
      .time_left   (tl),
      .busy        (busy),
      .expired     (expired)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_cnt[k] = '0; m_rel[k] = '0; m_run[k] = 0; m_per[k] = 0; m_exp[k] = 0; m_pau[k] = 0;
      end
   endtask

   // Behavioural rules: start > stop > pause > (zero-count or tick) per channel.
   task automatic model_step();
      for (int k = 0; k < 2; k++) begin
         m_exp[k] = 0;
         if (start[k]) begin
            m_cnt[k] = value[k*4 +: 4]; m_rel[k] = value[k*4 +: 4];
            m_per[k] = ar[k]; m_run[k] = 1; m_pau[k] = 0;
         end else if (stop[k]) begin
            m_run[k] = 0; m_cnt[k] = 0; m_pau[k] = 0;
         end else if (m_run[k] && (pause[k] || m_pau[k])) begin
            m_pau[k] = pause[k];
         end else if (m_run[k] && (m_cnt[k] == 0 || (tick && m_cnt[k] == 1))) begin
            m_exp[k] = 1;
            if (m_per[k]) m_cnt[k] = m_rel[k];
            else begin m_cnt[k] = 0; m_run[k] = 0; end
         end else if (m_run[k] && tick) m_cnt[k] = m_cnt[k] - 4'd1;
      end
   endtask

   task automatic cycle();
      model_step();
      @(posedge clk);
      #1;
      chk("model_time_left", tl, {m_cnt[1], m_cnt[0]});
      chk("model_busy", {6'd0, busy}, {6'd0, m_run[1], m_run[0]});
      chk("model_expired", {6'd0, expired}, {6'd0, m_exp[1], m_exp[0]});
   endtask

   task automatic drive(input logic [1:0] st, input logic [1:0] sp, input logic [1:0] a,
                        input logic [7:0] v, input logic tk);
      start = st; stop = sp; ar = a; value = v; tick = tk;
   endtask

   task automatic async_reset();
      #2 rst = 1'b1;
      #1;
      chk("rst_time_left", tl, 8'h00);
      chk("rst_busy", {6'd0, busy}, 8'h00);
      chk("rst_expired", {6'd0, expired}, 8'h00);
      model_reset();
      #1 rst = 1'b0;
   endtask

   initial begin
      model_reset();
      tbl.push_back('{2'b01, 2'b00, 2'b00, 8'h03, 1'b0, 8'h03, 2'b01, 2'b00});
      tbl.push_back('{2'b00, 2'b00, 2'b00, 8'h00, 1'b1, 8'h02, 2'b01, 2'b00});
      tbl.push_back('{2'b00, 2'b00, 2'b00, 8'h00, 1'b1, 8'h01, 2'b01, 2'b00});
      tbl.push_back('{2'b00, 2'b00, 2'b00, 8'h00, 1'b1, 8'h00, 2'b00, 2'b01});
      tbl.push_back('{2'b00, 2'b00, 2'b00, 8'h00, 1'b0, 8'h00, 2'b00, 2'b00});
      tbl.push_back('{2'b00, 2'b00, 2'b00, 8'h00, 1'b1, 8'h00, 2'b00, 2'b00});
      tbl.push_back('{2'b10, 2'b00, 2'b10, 8'h20, 1'b0, 8'h20, 2'b10, 2'b00});
      for (int i = 0; i < 3; i++) begin
         tbl.push_back('{2'b00, 2'b00, 2'b00, 8'h00, 1'b1, 8'h10, 2'b10, 2'b00});
         tbl.push_back('{2'b00, 2'b00, 2'b00, 8'h00, 1'b1, 8'h20, 2'b10, 2'b10});
      end
      tbl.push_back('{2'b00, 2'b10, 2'b00, 8'h00, 1'b0, 8'h00, 2'b00, 2'b00});
      tbl.push_back('{2'b01, 2'b00, 2'b00, 8'h00, 1'b0, 8'h00, 2'b01, 2'b00});
      tbl.push_back('{2'b00, 2'b00, 2'b00, 8'h00, 1'b0, 8'h00, 2'b00, 2'b01});
      tbl.push_back('{2'b00, 2'b00, 2'b00, 8'h00, 1'b0, 8'h00, 2'b00, 2'b00});
      tbl.push_back('{2'b01, 2'b00, 2'b01, 8'h00, 1'b0, 8'h00, 2'b01, 2'b00});
      tbl.push_back('{2'b00, 2'b00, 2'b00, 8'h00, 1'b0, 8'h00, 2'b01, 2'b01});
      tbl.push_back('{2'b00, 2'b00, 2'b00, 8'h00, 1'b1, 8'h00, 2'b01, 2'b01});
      tbl.push_back('{2'b00, 2'b01, 2'b00, 8'h00, 1'b0, 8'h00, 2'b00, 2'b00});
      tbl.push_back('{2'b01, 2'b00, 2'b00, 8'h01, 1'b0, 8'h01, 2'b01, 2'b00});
      tbl.push_back('{2'b01, 2'b00, 2'b00, 8'h05, 1'b1, 8'h05, 2'b01, 2'b00});
      tbl.push_back('{2'b00, 2'b00, 2'b00, 8'h00, 1'b0, 8'h05, 2'b01, 2'b00});
      tbl.push_back('{2'b00, 2'b01, 2'b00, 8'h00, 1'b0, 8'h00, 2'b00, 2'b00});
      tbl.push_back('{2'b00, 2'b11, 2'b00, 8'h00, 1'b1, 8'h00, 2'b00, 2'b00});

      repeat (2) @(posedge clk);
      #1;
      chk("reset_time_left", tl, 8'h00);
      chk("reset_busy", {6'd0, busy}, 8'h00);
      chk("reset_expired", {6'd0, expired}, 8'h00);
      rst = 1'b0;

      foreach (tbl[i]) begin
         drive(tbl[i].st, tbl[i].sp, tbl[i].ar, tbl[i].val, tbl[i].tk);
         cycle();
         chk($sformatf("vec%0d_time_left", i), tl, tbl[i].tl);
         chk($sformatf("vec%0d_busy", i), {6'd0, busy}, {6'd0, tbl[i].bs});
         chk($sformatf("vec%0d_expired", i), {6'd0, expired}, {6'd0, tbl[i].ex});
      end

      // stop one channel mid-count, then reset the other mid-count between edges
      drive(2'b11, 2'b00, 2'b00, 8'h64, 1'b0); cycle();
      drive(2'b00, 2'b00, 2'b00, 8'h00, 1'b1); cycle(); cycle();
      chk("pre_stop_time_left", tl, 8'h42);
      drive(2'b00, 2'b01, 2'b00, 8'h00, 1'b0); cycle();
      chk("stop_time_left", tl, 8'h40);
      chk("stop_expired", {6'd0, expired}, 8'h00);
      drive(2'b00, 2'b00, 2'b00, 8'h00, 1'b1); cycle();
      chk("count_ch1_time_left", tl, 8'h30);
      drive(2'b00, 2'b00, 2'b00, 8'h00, 1'b0);
      async_reset();
      drive(2'b01, 2'b00, 2'b00, 8'h07, 1'b0); cycle();
      chk("first_start_time_left", tl, 8'h07);
      chk("first_start_busy", {6'd0, busy}, 8'h01);
      drive(2'b00, 2'b11, 2'b00, 8'h00, 1'b0); cycle();

`ifdef PHASE_TIMER_PAUSE_EN
      drive(2'b01, 2'b00, 2'b00, 8'h05, 1'b0); cycle();
      drive(2'b00, 2'b00, 2'b00, 8'h00, 1'b1); cycle(); cycle();
      pause = 2'b01;
      repeat (4) begin
         cycle();
         chk("paused_time_left", tl, 8'h03);
         chk("paused_busy", {6'd0, busy}, 8'h01);
      end
      pause = 2'b00; tick = 1'b0; cycle();
      chk("unpause_time_left", tl, 8'h03);
      tick = 1'b1; cycle();
      chk("resume_time_left", tl, 8'h02);
      drive(2'b00, 2'b11, 2'b00, 8'h00, 1'b0); cycle();
`endif

      for (int i = 0; i < 600; i++) begin
         for (int k = 0; k < 2; k++) begin
            start[k] = ($urandom_range(0, 7) == 0);
            stop[k]  = ($urandom_range(0, 15) == 0);
            ar[k]    = $urandom_range(0, 1);
`ifdef PHASE_TIMER_PAUSE_EN
            if ($urandom_range(0, 5) == 0) pause[k] = ~pause[k];
`endif
         end
         value = 8'($urandom);
         if ($urandom_range(0, 3) == 0) value[3:0] = 4'd0;
         tick = ($urandom_range(0, 2) == 0);
         cycle();
         if (i % 150 == 149) async_reset();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
